// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the matrix keypad scanner
//
// Purpose: scan FSM state encoding, frame-result kinds and the key-code width
// helper shared by keypad_scan and its bench.
// Ports: none (package).

package keypad_pkg;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        EVAL   = 2'd3
    } state_t;

    // Classification of one complete keypad frame.
    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_t;

    // Width needed to hold a key index in 0 .. n-1; never narrower than 1 bit.
    function automatic int code_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with set-to-one reset
//
// Purpose: brings asynchronous, active-low, pulled-up lines into the clk
// domain. Resets to all ones so an idle bus reads as "nothing closed".
// Ports:
//   clk   in  1  sampling clock
//   nrst  in  1  synchronous active-low reset
//   d     in  W  asynchronous input lines
//   q     out W  synchronised copy of d, two cycles late

module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - row-scanning matrix keypad reader with frame debounce
//
// Purpose: drives one keypad row low at a time, samples the synchronised
// column lines, classifies each full frame as no key / one key / several
// keys, debounces frame results and reports accepted single-key presses.
// Ports:
//   clk        in   1       system clock, all logic on posedge
//   nrst       in   1       synchronous active-low reset
//   en         in   1       scan enable; low parks the scanner in IDLE
//   col_in     in   COLS    raw column lines, 0 = contact closed
//   row_out    out  ROWS    row drive, one bit low while scanning a row
//   key_code   out  CODE_W  row*COLS+col of the last accepted key
//   key_valid  out  1       one-cycle pulse per newly accepted key
//   key_held   out  1       accepted single key still debounced-pressed
//   multi_key  out  1       debounced frame result is "several keys"

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SETTLE     = 3,
    parameter int DEB_FRAMES = 3,
    parameter int CODE_W     = code_width(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);

    localparam int NKEY = ROWS * COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW   = $clog2(SETTLE + 1);
    localparam int CW   = $clog2(DEB_FRAMES + 1);

    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);
    localparam logic [CW-1:0] DEB_MAX     = CW'(DEB_FRAMES);

    // ------------------------------------------------------------------
    // Column synchroniser
    // ------------------------------------------------------------------
    logic [COLS-1:0] col_sync;

    sync2 #(
        .W(COLS)
    ) u_col_sync (
        .clk (clk),
        .nrst(nrst),
        .d   (col_in),
        .q   (col_sync)
    );

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [RW-1:0]   row_q,   row_d;
    logic [SW-1:0]   settle_q, settle_d;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        if (!en) begin
            // Dropping enable abandons whatever frame was in progress.
            state_d  = IDLE;
            row_d    = '0;
            settle_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end
                DRIVE: begin
                    if (settle_q == LAST_SETTLE) begin
                        state_d  = SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    // The row index only wraps back to 0 through EVAL.
                    if (row_q == LAST_ROW) begin
                        state_d = EVAL;
                    end else begin
                        state_d = DRIVE;
                        row_d   = row_q + 1'b1;
                    end
                end
                EVAL: begin
                    state_d  = DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end
                default: begin
                    state_d  = IDLE;
                    row_d    = '0;
                    settle_d = '0;
                end
            endcase
        end
    end

    // Row drive is decoded from registered state, so it changes only on clk.
    always_comb begin
        row_out = '1;
        if (state_q == DRIVE || state_q == SAMPLE) begin
            row_out[row_q] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulator: one bit per key, 1 = contact closed
    // ------------------------------------------------------------------
    logic [NKEY-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            frame_q <= '0;
        end else if (en && state_q == SAMPLE) begin
            frame_q[int'(row_q) * COLS +: COLS] <= ~col_sync;
        end
    end

    // ------------------------------------------------------------------
    // Frame classification
    // ------------------------------------------------------------------
    res_kind_t         res_kind;
    logic [CODE_W-1:0] res_code;
    logic [1:0]        n_hits;     // saturates at 2: "more than one"

    always_comb begin
        n_hits   = 2'd0;
        res_code = '0;
        for (int i = 0; i < NKEY; i++) begin
            if (frame_q[i]) begin
                if (n_hits == 2'd0) begin
                    res_code = CODE_W'(i);
                end
                if (n_hits != 2'd2) begin
                    n_hits = n_hits + 2'd1;
                end
            end
        end
        // Non-key results carry code 0 so kind+code compare as a single value.
        if (n_hits != 2'd1) begin
            res_code = '0;
        end
        unique case (n_hits)
            2'd0:    res_kind = RES_NONE;
            2'd1:    res_kind = RES_KEY;
            default: res_kind = RES_MULTI;
        endcase
    end

    // ------------------------------------------------------------------
    // Debounce and accepted result
    // ------------------------------------------------------------------
    res_kind_t         prev_kind, acc_kind;
    logic [CODE_W-1:0] prev_code, acc_code;
    logic [CW-1:0]     cnt_q, cnt_next;
    logic              same_prev, same_acc, accept;

    always_comb begin
        same_prev = (res_kind == prev_kind) && (res_code == prev_code);
        same_acc  = (res_kind == acc_kind)  && (res_code == acc_code);
        if (!same_prev) begin
            cnt_next = CW'(1);
        end else if (cnt_q >= DEB_MAX) begin
            cnt_next = DEB_MAX;
        end else begin
            cnt_next = cnt_q + 1'b1;
        end
        accept = (state_q == EVAL) && (cnt_next == DEB_MAX) && !same_acc;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_kind <= RES_NONE;
            prev_code <= '0;
            acc_kind  <= RES_NONE;
            acc_code  <= '0;
            cnt_q     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else if (!en) begin
            // Idle: forget debounce history; key_code keeps the last key.
            prev_kind <= RES_NONE;
            prev_code <= '0;
            acc_kind  <= RES_NONE;
            acc_code  <= '0;
            cnt_q     <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (state_q == EVAL) begin
                prev_kind <= res_kind;
                prev_code <= res_code;
                cnt_q     <= cnt_next;
            end
            if (accept) begin
                acc_kind <= res_kind;
                acc_code <= res_code;
                unique case (res_kind)
                    RES_KEY: begin
                        key_code  <= res_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        multi_key <= 1'b0;
                    end
                    RES_MULTI: begin
                        key_held  <= 1'b0;
                        multi_key <= 1'b1;
                    end
                    default: begin
                        key_held  <= 1'b0;
                        multi_key <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan

module tb_keypad_scan;

    localparam int R_NONE  = -1;
    localparam int R_MULTI = -2;
    localparam int FRAME   = 17;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    logic [15:0] pressed;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state (frame granularity)
    int hist[$];
    int acc;
    int exp_code;
    bit exp_held;
    bit exp_multi;

    always #5 clk = ~clk;

    keypad_scan dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .multi_key(multi_key)
    );

    // Physical keypad: a closed key pulls its column low when its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && pressed[r * 4 + c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    function automatic int classify(input logic [15:0] ks);
        int n;
        int k;
        n = 0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (ks[i]) begin
                n = n + 1;
                k = i;
            end
        end
        if (n == 0) return R_NONE;
        if (n > 1)  return R_MULTI;
        return k;
    endfunction

    function automatic void model_clear(input bit full);
        hist.delete();
        acc       = R_NONE;
        exp_held  = 1'b0;
        exp_multi = 1'b0;
        if (full) exp_code = 0;
    endfunction

    // A result is accepted once the last three frames agree and it is new.
    function automatic int model_frame(input int res);
        int pulse;
        pulse = 0;
        hist.push_back(res);
        if (hist.size() > 3) void'(hist.pop_front());
        if (hist.size() == 3 && hist[0] == res && hist[1] == res && res != acc) begin
            acc = res;
            if (res >= 0) begin
                exp_code  = res;
                exp_held  = 1'b1;
                exp_multi = 1'b0;
                pulse     = 1;
            end else if (res == R_MULTI) begin
                exp_held  = 1'b0;
                exp_multi = 1'b1;
            end else begin
                exp_held  = 1'b0;
                exp_multi = 1'b0;
            end
        end
        return pulse;
    endfunction

    // Called at the negedge just after a frame starts (row 0 driven).
    task automatic do_frame(input logic [15:0] ks, input string tag);
        int         pulses;
        int         exp_pulses;
        int         pos;
        logic [3:0] exp_row;
        pulses  = 0;
        pressed = ks;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) pulses++;
            pos     = i % FRAME;
            exp_row = 4'hF;
            if (pos != 16) exp_row[pos / 4] = 1'b0;
            tests_run++;
            if (row_out !== exp_row) begin
                tests_failed++;
                $display("FAIL %s row_out pos %0d: got %h want %h", tag, pos, row_out, exp_row);
            end
        end
        exp_pulses = model_frame(classify(ks));
        tests_run++;
        if (pulses != exp_pulses) begin
            tests_failed++;
            $display("FAIL %s key_valid pulses: got %0d want %0d", tag, pulses, exp_pulses);
        end
        tests_run++;
        if (key_code !== 4'(exp_code)) begin
            tests_failed++;
            $display("FAIL %s key_code: got %0d want %0d", tag, key_code, exp_code);
        end
        tests_run++;
        if (key_held !== exp_held) begin
            tests_failed++;
            $display("FAIL %s key_held: got %b want %b", tag, key_held, exp_held);
        end
        tests_run++;
        if (multi_key !== exp_multi) begin
            tests_failed++;
            $display("FAIL %s multi_key: got %b want %b", tag, multi_key, exp_multi);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [3:0] want_code);
        tests_run++;
        if (row_out !== 4'hF) begin
            tests_failed++;
            $display("FAIL %s row_out: got %h want f", tag, row_out);
        end
        tests_run++;
        if (key_code !== want_code) begin
            tests_failed++;
            $display("FAIL %s key_code: got %0d want %0d", tag, key_code, want_code);
        end
        tests_run++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || multi_key !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s flags valid/held/multi: got %b%b%b want 000", tag,
                     key_valid, key_held, multi_key);
        end
    endtask

    task automatic start_scan();
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst    = 1'b0;
        en      = 1'b1;
        pressed = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 4'd0);
        en      = 1'b0;
        nrst    = 1'b1;
        pressed = '0;
        @(negedge clk);
        check_idle_outputs("reset_release_en0", 4'd0);
        model_clear(1'b1);
    endtask

    task automatic test_bounce();
        logic [15:0] k0;
        k0     = '0;
        k0[0]  = 1'b1;
        do_frame(k0, "bounce_k0_f1");
        do_frame(k0, "bounce_k0_f2");
        repeat (3) do_frame('0, "bounce_release");
    endtask

    task automatic test_single_press();
        logic [15:0] k9;
        k9    = '0;
        k9[9] = 1'b1;
        for (int f = 0; f < 5; f++) do_frame(k9, $sformatf("press9_f%0d", f + 1));
        for (int f = 0; f < 3; f++) do_frame('0, $sformatf("release9_f%0d", f + 1));
    endtask

    task automatic test_multi();
        logic [15:0] k56;
        k56    = '0;
        k56[5] = 1'b1;
        k56[6] = 1'b1;
        for (int f = 0; f < 4; f++) do_frame(k56, $sformatf("multi_f%0d", f + 1));
        for (int f = 0; f < 3; f++) do_frame('0, $sformatf("multi_rel_f%0d", f + 1));
    endtask

    task automatic test_key_change();
        logic [15:0] k15;
        logic [15:0] k3;
        k15     = '0;
        k15[15] = 1'b1;
        k3      = '0;
        k3[3]   = 1'b1;
        for (int f = 0; f < 3; f++) do_frame(k15, $sformatf("k15_f%0d", f + 1));
        for (int f = 0; f < 3; f++) do_frame(k3, $sformatf("k15_to_k3_f%0d", f + 1));
        repeat (3) do_frame('0, "k3_release");
    endtask

    task automatic test_en_drop();
        logic [15:0] k7;
        k7    = '0;
        k7[7] = 1'b1;
        for (int f = 0; f < 3; f++) do_frame(k7, $sformatf("k7_f%0d", f + 1));
        repeat (9) @(negedge clk);          // mid-row-2
        en = 1'b0;
        @(negedge clk);
        check_idle_outputs("en_drop", 4'd7);
        model_clear(1'b0);
        start_scan();
        for (int f = 0; f < 3; f++) do_frame(k7, $sformatf("k7_reen_f%0d", f + 1));
        repeat (3) do_frame('0, "k7_release");
    endtask

    task automatic test_reset_mid();
        logic [15:0] k5;
        k5    = '0;
        k5[5] = 1'b1;
        for (int f = 0; f < 3; f++) do_frame(k5, $sformatf("k5_f%0d", f + 1));
        repeat (3) @(negedge clk);          // row 0 SAMPLE cycle
        nrst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_mid", 4'd0);
        nrst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (row_out !== 4'b1110) begin
            tests_failed++;
            $display("FAIL reset_mid_restart row_out: got %h want e", row_out);
        end
        model_clear(1'b1);
        for (int f = 0; f < 3; f++) do_frame(k5, $sformatf("k5_after_rst_f%0d", f + 1));
        repeat (3) do_frame('0, "k5_release");
    endtask

    task automatic test_random();
        logic [15:0] ks;
        int          kind;
        int          len;
        int          a;
        int          b;
        for (int seg = 0; seg < 18; seg++) begin
            kind = $urandom_range(0, 3);
            ks   = '0;
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            if (kind != 0) ks[a] = 1'b1;
            if (kind == 3) ks[b] = 1'b1;
            len = $urandom_range(1, 5);
            for (int f = 0; f < len; f++) do_frame(ks, $sformatf("rand_s%0d_f%0d", seg, f));
        end
    endtask

    initial begin
        test_reset();
        start_scan();
        do_frame('0, "warmup");
        test_bounce();
        test_single_press();
        test_multi();
        test_key_change();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
